// File: rtl/robertsons_mult_seq.sv
// robertsons_mult_seq: sequential signed/unsigned shift-add multiplier
// (Robertson's algorithm) with a start/busy/done handshake.
//
// The datapath examines one multiplier bit per RUN cycle.
// - Unsigned operands: the partial product is added, then shifted right
//   logically; the carry bit becomes the new MSB.
// - Signed operands: the partial product is added, then shifted right
//   arithmetically. The sign-bit iteration subtracts instead of adding,
//   because that bit carries weight -2^(WIDTH-1).
//
// Optional build macro: ROBERTSONS_EARLY_TERM_EN
//   When defined, a RUN cycle whose remaining multiplier bits are all zero
//   finishes the operation by shifting out all remaining positions at once.
//   Products are identical with and without the macro; only latency differs.
module robertsons_mult_seq #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               reset,         // async, active low
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic [WIDTH-1:0]   multiplicand,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;        // latched multiplicand
    logic [WIDTH-1:0]   q_q, q_d;        // multiplier, low half of the product
    logic [WIDTH:0]     acc_q, acc_d;    // high half plus one guard/carry bit
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               mode_q, mode_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;

    // One Robertson iteration
    logic [WIDTH:0]     m_ext;
    logic [WIDTH:0]     sum;
    logic               fill;
    logic [WIDTH:0]     acc_n;
    logic [WIDTH-1:0]   q_n;

`ifdef ROBERTSONS_EARLY_TERM_EN
    // Early termination: remaining multiplier bits are the low WIDTH-cnt
    // bits of q_q, since the examined bits have already been shifted out.
    logic [WIDTH-1:0]   rem_mask;
    logic               rem_zero;
    logic [CW:0]        sh_amt;
    logic [2*WIDTH:0]   joint;
    logic [2*WIDTH:0]   joint_sh;
`endif

    // Add/subtract the multiplicand and shift {acc,Q} right by one
    always_comb begin
        m_ext = mode_q ? {m_q[WIDTH-1], m_q} : {1'b0, m_q};
        sum   = acc_q;
        if (q_q[0]) begin
            if (mode_q && (cnt_q == LAST)) sum = acc_q - m_ext;
            else                           sum = acc_q + m_ext;
        end
        // Signed mode replicates the sign; unsigned mode shifts in zero
        // above the carry bit.
        fill  = mode_q ? sum[WIDTH] : 1'b0;
        acc_n = {fill, sum[WIDTH:1]};
        q_n   = {sum[0], q_q[WIDTH-1:1]};
    end

`ifdef ROBERTSONS_EARLY_TERM_EN
    // Collapse all remaining shifts into one when no set bits remain
    always_comb begin
        rem_mask = {WIDTH{1'b1}} >> cnt_q;
        rem_zero = ((q_q & rem_mask) == '0);
        sh_amt   = (CW+1)'(WIDTH) - {1'b0, cnt_q};
        joint    = {acc_q, q_q};
        if (mode_q) joint_sh = $signed(joint) >>> sh_amt;
        else        joint_sh = joint >> sh_amt;
    end
`endif

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        q_d     = q_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        prod_d  = prod_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d = S_RUN;
                    m_d     = multiplicand;
                    q_d     = multiplier;
                    mode_d  = signed_mode;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            S_RUN: begin
`ifdef ROBERTSONS_EARLY_TERM_EN
                if (rem_zero) begin
                    acc_d   = joint_sh[2*WIDTH:WIDTH];
                    q_d     = joint_sh[WIDTH-1:0];
                    cnt_d   = '0;
                    prod_d  = joint_sh[2*WIDTH-1:0];
                    state_d = S_DONE;
                end else begin
`endif
                    acc_d = acc_n;
                    q_d   = q_n;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        prod_d  = {acc_n[WIDTH-1:0], q_n};
                        state_d = S_DONE;
                    end
`ifdef ROBERTSONS_EARLY_TERM_EN
                end
`endif
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            m_q     <= '0;
            q_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            q_q     <= q_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            prod_q  <= prod_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = prod_q;

endmodule
